// File: rtl/dds_key_cfg_ctrl.sv
// rtl/dds_key_cfg_ctrl.sv - debounced key front end and handshaked frequency/waveform config source for the DDS core
module dds_key_cfg_ctrl #(
    parameter int DEB_CNT   = 500_000,
    parameter int FW_W      = 32,
    parameter int FW_MIN    = 85_899,
    parameter int FW_MAX    = 85_899_346,
    parameter int FW_STEP   = 85_899,
    parameter int SWEEP_DIV = 50_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      key_in,
    input  logic            cfg_ready,
    output logic            cfg_valid,
    output logic [FW_W-1:0] cfg_fword,
    output logic [1:0]      cfg_wave,
    output logic            sweep_on,
    output logic [3:0]      key_evt
);

    localparam int DCW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam int PCW = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CNT - 1);
    localparam logic [PCW-1:0] PRE_LAST = PCW'(SWEEP_DIV - 1);

    localparam logic [FW_W-1:0] FW_MIN_W  = FW_W'(FW_MIN);
    localparam logic [FW_W-1:0] FW_MAX_W  = FW_W'(FW_MAX);
    localparam logic [FW_W-1:0] FW_STEP_W = FW_W'(FW_STEP);
    localparam logic [FW_W:0]   FW_MAX_X  = {1'b0, FW_MAX_W};
    localparam logic [FW_W:0]   FW_STEP_X = {1'b0, FW_STEP_W};
    localparam logic [FW_W:0]   DEC_LIMIT = {1'b0, FW_MIN_W} + FW_STEP_X;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [3:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]      stable_q, stable_d;
    logic [DCW-1:0]  deb_cnt_q [4];
    logic [DCW-1:0]  deb_cnt_d [4];
    logic [3:0]      key_evt_q, key_evt_d;
    logic [FW_W-1:0] fword_q, fword_d;
    logic [1:0]      wave_q, wave_d;
    logic            sweep_q, sweep_d;
    logic [PCW-1:0]  pre_q, pre_d;
    logic            pending_q, pending_d;
    logic [0:0]      state_q, state_d;
    logic [FW_W-1:0] cfg_fword_q, cfg_fword_d;
    logic [1:0]      cfg_wave_q, cfg_wave_d;

    logic [3:0]      press;
    logic            tick;
    logic [FW_W:0]   fw_inc;
    logic [FW_W-1:0] fw_up, fw_dn, fw_sweep;
    logic            cfg_update;

    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
                end
            end
        end
        press     = stable_q & ~stable_d;
        key_evt_d = press;
    end

    // Wide sum so a step near the top of the range cannot wrap before the limit check.
    always_comb begin
        fw_inc   = {1'b0, fword_q} + FW_STEP_X;
        fw_up    = (fw_inc > FW_MAX_X) ? FW_MAX_W : fw_inc[FW_W-1:0];
        fw_sweep = (fw_inc > FW_MAX_X) ? FW_MIN_W : fw_inc[FW_W-1:0];
        fw_dn    = ({1'b0, fword_q} >= DEC_LIMIT) ? (fword_q - FW_STEP_W) : FW_MIN_W;
        tick     = sweep_q && (pre_q == PRE_LAST);

        fword_d = fword_q;
        wave_d  = wave_q;
        sweep_d = sweep_q;
        pre_d   = '0;
        if (press[3]) begin
            sweep_d = ~sweep_q;
            if (!sweep_q) begin
                fword_d = FW_MIN_W;
            end
        end else begin
            if (sweep_q) begin
                pre_d = tick ? '0 : pre_q + PCW'(1);
                if (tick) begin
                    fword_d = fw_sweep;
                end
            end
            if (press[2]) begin
                wave_d = (wave_q == 2'd2) ? 2'd0 : wave_q + 2'd1;
            end else if (!sweep_q && press[0]) begin
                fword_d = fw_up;
            end else if (!sweep_q && press[1]) begin
                fword_d = fw_dn;
            end
        end
        cfg_update = (fword_d != fword_q) || (wave_d != wave_q);
    end

    // A change landing on the load cycle keeps pending set so the newer value is re-offered.
    always_comb begin
        state_d     = state_q;
        cfg_fword_d = cfg_fword_q;
        cfg_wave_d  = cfg_wave_q;
        pending_d   = pending_q;
        if (state_q == ST_IDLE) begin
            if (pending_q) begin
                state_d     = ST_OFFER;
                cfg_fword_d = fword_q;
                cfg_wave_d  = wave_q;
                pending_d   = 1'b0;
            end
        end else if (cfg_ready) begin
            state_d = ST_IDLE;
        end
        if (cfg_update) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            stable_q    <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
            key_evt_q   <= '0;
            fword_q     <= FW_MIN_W;
            wave_q      <= '0;
            sweep_q     <= 1'b0;
            pre_q       <= '0;
            pending_q   <= 1'b1;
            state_q     <= ST_IDLE;
            cfg_fword_q <= FW_MIN_W;
            cfg_wave_q  <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stable_q    <= stable_d;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            key_evt_q   <= key_evt_d;
            fword_q     <= fword_d;
            wave_q      <= wave_d;
            sweep_q     <= sweep_d;
            pre_q       <= pre_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            cfg_fword_q <= cfg_fword_d;
            cfg_wave_q  <= cfg_wave_d;
        end
    end

    assign cfg_valid = (state_q == ST_OFFER);
    assign cfg_fword = cfg_fword_q;
    assign cfg_wave  = cfg_wave_q;
    assign sweep_on  = sweep_q;
    assign key_evt   = key_evt_q;

endmodule
